// File: rtl/l1_threshold_servo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : l1_servo_pkg
//  Purpose  : Shared types and helpers for the L1 threshold servo.
//             Holds the servo state encoding, the default threshold and
//             count widths, and the threshold clamp function.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package l1_servo_pkg;

  localparam int unsigned THRESH_BITS_DEF = 18;
  localparam int unsigned COUNT_BITS_DEF  = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_GAP    = 3'd3,
    ST_UPDATE = 3'd4,
    ST_START  = 3'd5,
    ST_WAIT   = 3'd6,
    ST_ADJUST = 3'd7
  } servo_state_t;

  // Widths up to 32 bits are handled by zero-extending at the call site.
  function automatic logic [31:0] clamp_u32(input logic [31:0] v,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/l1_threshold_servo_if.sv
`default_nettype none
// ============================================================================
//  Module   : l1_threshold_servo_if
//  Purpose  : Threshold-load and rate-counter handshake between the servo
//             and the beamform trigger.
//  Signals  : count_i       per-beam trigger counts (valid on count_done_i)
//             count_done_i  rate window complete pulse
//             count_start_o rate window start pulse
//             thresh_o      threshold being loaded
//             thresh_ce_o   one-hot per-beam load strobe
//             update_o      commit staged thresholds pulse
//  Modports : master = servo side, slave = trigger side
//  Revision : 1.0  initial release
// ============================================================================
interface l1_threshold_servo_if
  import l1_servo_pkg::*;
#(
  parameter int unsigned NBEAMS      = 2,
  parameter int unsigned THRESH_BITS = THRESH_BITS_DEF,
  parameter int unsigned COUNT_BITS  = COUNT_BITS_DEF
);
  logic [NBEAMS*COUNT_BITS-1:0] count_i;
  logic                         count_done_i;
  logic                         count_start_o;
  logic [THRESH_BITS-1:0]       thresh_o;
  logic [NBEAMS-1:0]            thresh_ce_o;
  logic                         update_o;

  modport master (
    input  count_i, count_done_i,
    output count_start_o, thresh_o, thresh_ce_o, update_o
  );

  modport slave (
    output count_i, count_done_i,
    input  count_start_o, thresh_o, thresh_ce_o, update_o
  );
endinterface
`default_nettype wire

// File: rtl/l1_threshold_servo_step.sv
`default_nettype none
// ============================================================================
//  Module   : l1_threshold_step
//  Purpose  : Combinational compare/step/clamp for one beam threshold.
//  Ports    : i_thresh      current threshold
//             i_count       captured trigger count for the window
//             i_target      desired count per window
//             i_deadband    hold tolerance around target
//             i_step        threshold increment/decrement
//             i_thresh_min  lower clamp
//             i_thresh_max  upper clamp
//             o_thresh      next threshold
//  Revision : 1.0  initial release
// ============================================================================
module l1_threshold_step #(
  parameter int unsigned THRESH_BITS = 18,
  parameter int unsigned COUNT_BITS  = 32,
  parameter int unsigned STEP_BITS   = 8
) (
  input  logic [THRESH_BITS-1:0] i_thresh,
  input  logic [COUNT_BITS-1:0]  i_count,
  input  logic [COUNT_BITS-1:0]  i_target,
  input  logic [COUNT_BITS-1:0]  i_deadband,
  input  logic [STEP_BITS-1:0]   i_step,
  input  logic [THRESH_BITS-1:0] i_thresh_min,
  input  logic [THRESH_BITS-1:0] i_thresh_max,
  output logic [THRESH_BITS-1:0] o_thresh
);
  // Upper band edge carries one extra bit so target+deadband cannot wrap.
  logic [COUNT_BITS:0]    w_hi;
  logic [COUNT_BITS-1:0]  w_lo;
  logic [THRESH_BITS:0]   w_up_sum;
  logic [THRESH_BITS-1:0] w_up;
  logic [THRESH_BITS-1:0] w_step_t;
  logic [THRESH_BITS-1:0] w_dn_diff;
  logic [THRESH_BITS-1:0] w_dn;

  assign w_hi      = {1'b0, i_target} + {1'b0, i_deadband};
  assign w_lo      = (i_target > i_deadband) ? (i_target - i_deadband) : '0;
  assign w_step_t  = THRESH_BITS'(i_step);

  assign w_up_sum  = {1'b0, i_thresh} + {1'b0, w_step_t};
  assign w_up      = (w_up_sum > {1'b0, i_thresh_max}) ? i_thresh_max
                                                       : w_up_sum[THRESH_BITS-1:0];

  // Subtract floors at zero before the lower clamp is applied.
  assign w_dn_diff = (i_thresh > w_step_t) ? (i_thresh - w_step_t) : '0;
  assign w_dn      = (w_dn_diff < i_thresh_min) ? i_thresh_min : w_dn_diff;

  // Counts exactly on a band edge hold the threshold.
  always_comb begin
    o_thresh = i_thresh;
    if ({1'b0, i_count} > w_hi) begin
      o_thresh = w_up;
    end else if (i_count < w_lo) begin
      o_thresh = w_dn;
    end
  end
endmodule
`default_nettype wire

// File: rtl/l1_threshold_servo.sv
`default_nettype none
// ============================================================================
//  Module   : l1_threshold_servo
//  Purpose  : Closed-loop scheduler for the L1 beam thresholds. Each
//             iteration loads every beam threshold, commits them, runs a
//             trigger-rate window and steps each threshold toward target.
//  Ports    : aclk, aresetn        clock, async active-low reset
//             enable_i             servo run request (level)
//             init_thresh_i        start threshold for all beams
//             thresh_min_i/max_i   clamp range
//             target_i/deadband_i  desired count and hold tolerance
//             step_i               threshold step
//             bus                  load/count handshake (master)
//             thresh_rd_o          current threshold registers
//             busy_o               high outside IDLE
//             iter_o               completed iteration count
//  Revision : 1.0  initial release
// ============================================================================
module l1_threshold_servo
  import l1_servo_pkg::*;
#(
  parameter int unsigned NBEAMS      = 2,
  parameter int unsigned THRESH_BITS = THRESH_BITS_DEF,
  parameter int unsigned COUNT_BITS  = COUNT_BITS_DEF,
  parameter int unsigned STEP_BITS   = 8,
  parameter int unsigned LOAD_GAP    = 2
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          enable_i,
  input  logic [THRESH_BITS-1:0]        init_thresh_i,
  input  logic [THRESH_BITS-1:0]        thresh_min_i,
  input  logic [THRESH_BITS-1:0]        thresh_max_i,
  input  logic [COUNT_BITS-1:0]         target_i,
  input  logic [COUNT_BITS-1:0]         deadband_i,
  input  logic [STEP_BITS-1:0]          step_i,
  l1_threshold_servo_if.master          bus,
  output logic [NBEAMS*THRESH_BITS-1:0] thresh_rd_o,
  output logic                          busy_o,
  output logic [15:0]                   iter_o
);
  localparam int unsigned c_IDX_W = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;
  localparam int unsigned c_GAP_W = (LOAD_GAP > 1) ? $clog2(LOAD_GAP) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NBEAMS - 1);
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((LOAD_GAP > 0) ? LOAD_GAP - 1 : 0);

  servo_state_t           r_state, w_state_nxt;
  logic [c_IDX_W-1:0]     r_idx;
  logic [c_GAP_W-1:0]     r_gap_cnt;
  logic [THRESH_BITS-1:0] r_thresh [NBEAMS];
  logic [COUNT_BITS-1:0]  r_count  [NBEAMS];
  logic [THRESH_BITS-1:0] r_thresh_last;
  logic [15:0]            r_iter;

  logic                   w_last_beam;
  logic                   w_gap_done;
  logic [c_IDX_W-1:0]     w_idx_adv;
  logic [THRESH_BITS-1:0] w_thresh_init;
  logic [THRESH_BITS-1:0] w_step_next;

  assign w_last_beam   = (r_idx == c_LAST_IDX);
  assign w_gap_done    = (r_gap_cnt == c_GAP_LAST);
  assign w_idx_adv     = w_last_beam ? '0 : (r_idx + c_IDX_W'(1));
  assign w_thresh_init = THRESH_BITS'(clamp_u32(32'(init_thresh_i),
                                                32'(thresh_min_i),
                                                32'(thresh_max_i)));

  // Single step datapath shared by all beams; ADJUST walks r_idx across it.
  l1_threshold_step #(
    .THRESH_BITS (THRESH_BITS),
    .COUNT_BITS  (COUNT_BITS),
    .STEP_BITS   (STEP_BITS)
  ) u_step (
    .i_thresh     (r_thresh[r_idx]),
    .i_count      (r_count[r_idx]),
    .i_target     (target_i),
    .i_deadband   (deadband_i),
    .i_step       (step_i),
    .i_thresh_min (thresh_min_i),
    .i_thresh_max (thresh_max_i),
    .o_thresh     (w_step_next)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (enable_i) w_state_nxt = ST_INIT;
      ST_INIT:   w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (LOAD_GAP != 0)    w_state_nxt = ST_GAP;
        else if (w_last_beam) w_state_nxt = ST_UPDATE;
        else                  w_state_nxt = ST_LOAD;
      end
      ST_GAP:    if (w_gap_done) w_state_nxt = w_last_beam ? ST_UPDATE : ST_LOAD;
      ST_UPDATE: w_state_nxt = ST_START;
      ST_START:  w_state_nxt = ST_WAIT;
      ST_WAIT:   if (bus.count_done_i) w_state_nxt = ST_ADJUST;
      ST_ADJUST: if (w_last_beam) w_state_nxt = enable_i ? ST_LOAD : ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_idx         <= '0;
      r_gap_cnt     <= '0;
      r_thresh_last <= '0;
      r_iter        <= '0;
      for (int b = 0; b < NBEAMS; b++) begin
        r_thresh[b] <= '0;
        r_count[b]  <= '0;
      end
    end else begin
      case (r_state)
        ST_INIT: begin
          r_idx <= '0;
          for (int b = 0; b < NBEAMS; b++) r_thresh[b] <= w_thresh_init;
        end
        ST_LOAD: begin
          // Remember the loaded value so thresh_o holds it after LOAD.
          r_thresh_last <= r_thresh[r_idx];
          r_gap_cnt     <= '0;
          if (LOAD_GAP == 0) r_idx <= w_idx_adv;
        end
        ST_GAP: begin
          r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
          if (w_gap_done) begin
            r_gap_cnt <= '0;
            r_idx     <= w_idx_adv;
          end
        end
        ST_WAIT: begin
          if (bus.count_done_i) begin
            for (int b = 0; b < NBEAMS; b++)
              r_count[b] <= bus.count_i[b*COUNT_BITS +: COUNT_BITS];
          end
        end
        ST_ADJUST: begin
          r_thresh[r_idx] <= w_step_next;
          r_idx           <= w_idx_adv;
          if (w_last_beam) r_iter <= r_iter + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.thresh_ce_o   = (r_state == ST_LOAD) ? (NBEAMS'(1) << r_idx) : '0;
  assign bus.thresh_o      = (r_state == ST_LOAD) ? r_thresh[r_idx] : r_thresh_last;
  assign bus.update_o      = (r_state == ST_UPDATE);
  assign bus.count_start_o = (r_state == ST_START);
  assign busy_o            = (r_state != ST_IDLE);
  assign iter_o            = r_iter;

  generate
    for (genvar b = 0; b < NBEAMS; b++) begin : g_beam_rd
      assign thresh_rd_o[b*THRESH_BITS +: THRESH_BITS] = r_thresh[b];
    end
  endgenerate
endmodule
`default_nettype wire
